// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared constants and FSM state type for the uart_tx byte FIFO
//
// Purpose: state encoding of the send sequencer, ASCII constants used by the
// optional CR/LF expansion, and the uart_tx busy-handshake timeout.
// Ports: none (package).

package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_fifo_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Cycles spent in WAIT_HI without seeing tx_busy before the byte is
  // considered sent (uart_tx may have missed or already finished it).
  localparam int TX_BUSY_TIMEOUT = 4;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - simple dual-port RAM, synchronous write, asynchronous read
//
// Purpose: storage array for the uart_tx byte FIFO.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)

module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO with send sequencer feeding uart_tx
//
// Purpose: buffers bytes from producers and drains them one at a time into
// uart_tx using its send/busy handshake, so no byte is lost while uart_tx
// is busy.
// Build option: UART_TX_FIFO_CRLF_EN - when defined, a written LF (8'h0A)
// is stored as CR then LF over two consecutive cycles.
// Ports:
//   CLK       in   system clock
//   RST       in   asynchronous reset, active-high
//   wr_data   in   byte to enqueue
//   wr_en     in   enqueue strobe, one byte per high cycle
//   full      out  no free entry
//   empty     out  no stored entry
//   count     out  stored entries, 0..2**DEPTH_LOG2
//   overflow  out  sticky dropped-write flag, cleared only by RST
//   tx_byte   out  byte presented to uart_tx
//   tx_send   out  one-cycle send strobe to uart_tx
//   tx_busy   in   busy from uart_tx

module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] tx_byte,
  output logic                  tx_send,
  input  logic                  tx_busy
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TX_BUSY_TIMEOUT);

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  drop;
  logic                  pop;
  logic [TW-1:0]         hi_cnt;

  tx_fifo_state_t state;
  tx_fifo_state_t state_nxt;

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (wptr[DEPTH_LOG2-1:0]),
    .wdata (mem_wdata),
    .raddr (rptr[DEPTH_LOG2-1:0]),
    .rdata (mem_rdata)
  );

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                 (wptr[PW-2:0] == rptr[PW-2:0]);
  assign count = wptr - rptr;

  // Write path. A write while full is still accepted when a pop happens on
  // the same edge: the slot being written is the one being read out, and the
  // read is combinational, so the popped byte is captured before it is
  // overwritten.
`ifdef UART_TX_FIFO_CRLF_EN
  logic lf_pending;

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = wr_data;
    drop      = 1'b0;
    if (lf_pending) begin
      // Second half of a CR/LF pair; its slot was reserved last cycle.
      mem_we    = 1'b1;
      mem_wdata = DATA_WIDTH'(ASCII_LF);
      drop      = wr_en;
    end else if (wr_en && (wr_data == DATA_WIDTH'(ASCII_LF))) begin
      if (count <= PW'(DEPTH - 2)) begin
        mem_we    = 1'b1;
        mem_wdata = DATA_WIDTH'(ASCII_CR);
      end else begin
        drop = 1'b1;
      end
    end else if (wr_en) begin
      if (!full || pop) begin
        mem_we = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lf_pending <= 1'b0;
    end else begin
      lf_pending <= !lf_pending && wr_en &&
                    (wr_data == DATA_WIDTH'(ASCII_LF)) &&
                    (count <= PW'(DEPTH - 2));
    end
  end
`else
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = wr_data;
    drop      = 1'b0;
    if (wr_en) begin
      if (!full || pop) begin
        mem_we = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end
`endif

  // Send sequencer: state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Send sequencer: next state and outputs.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_send   = 1'b0;
    case (state)
      IDLE: begin
        // tx_busy here means another sender owns uart_tx; hold off.
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_send   = 1'b1;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (hi_cnt == TW'(TX_BUSY_TIMEOUT - 1)) begin
          state_nxt = IDLE;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers, timeout counter, output byte and sticky overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      hi_cnt   <= '0;
      tx_byte  <= '0;
      overflow <= 1'b0;
    end else begin
      if (mem_we) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr    <= rptr + PW'(1);
        tx_byte <= mem_rdata;
      end
      if (state == WAIT_HI) begin
        hi_cnt <= hi_cnt + TW'(1);
      end else begin
        hi_cnt <= '0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with byte scoreboard

module tb_uart_tx_fifo;

  logic       CLK;
  logic       RST;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] tx_byte;
  logic       tx_send;
  logic       tx_busy;

  logic       force_busy;
  logic       model_en;
  int         model_cnt;
  int         frame_len;

  int         checks;
  int         errors;
  int         sends;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(
    .DATA_WIDTH (8),
    .DEPTH_LOG2 (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_byte  (tx_byte),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // uart_tx busy model: busy for frame_len cycles after each send strobe.
  // Deliberately not reset by RST, since a frame in flight is not aborted.
  initial model_cnt = 0;
  always @(posedge CLK) begin
    if (model_en && tx_send) begin
      model_cnt <= frame_len;
    end else if (model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
    end
  end
  assign tx_busy = force_busy | (model_cnt != 0);

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Scoreboard side: every send strobe pops the next expected byte.
  always @(negedge CLK) begin
    if (tx_send === 1'b1) begin
      sends++;
      if (exp_q.size() == 0) begin
        check("unexpected_send", 32'd1, 32'd0);
      end else begin
        check("tx_byte_order", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
      end
      check("send_busy_overlap", {31'd0, tx_busy}, 32'd0);
    end
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit push);
    wr_en   = 1'b1;
    wr_data = b;
    if (push) exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset;
    RST   = 1'b1;
    wr_en = 1'b0;
    step();
    step();
    exp_q.delete();
    RST = 1'b0;
    step();
  endtask

  task automatic wait_sends(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (sends < target && n < limit) begin
      step();
      n++;
    end
    check(name, {31'd0, sends >= target}, 32'd1);
  endtask

  task automatic wait_model_idle;
    int n;
    n = 0;
    while (model_cnt != 0 && n < 200) begin
      step();
      n++;
    end
    check("model_idle", model_cnt, 32'd0);
  endtask

  initial begin
    int base;
    checks     = 0;
    errors     = 0;
    sends      = 0;
    RST        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    force_busy = 1'b0;
    model_en   = 1'b0;
    frame_len  = 80;

    // Reset state
    step();
    step();
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_tx_send", {31'd0, tx_send}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    RST = 1'b0;
    step();

    // 1. Single byte latency: write in cycle 0, tx_send in cycle 2
    write_byte(8'h41, 1'b1);
    check("lat_cycle1_send", {31'd0, tx_send}, 32'd0);
    step();
    check("lat_cycle2_send", {31'd0, tx_send}, 32'd1);
    check("lat_cycle2_byte", {24'd0, tx_byte}, 32'h41);
    check("lat_count", {27'd0, count}, 32'd0);
    check("lat_empty", {31'd0, empty}, 32'd1);
    step();
    check("send_one_cycle", {31'd0, tx_send}, 32'd0);
    repeat (6) step();
    check("t1_sends", sends, 32'd1);

    // 2. Fill to full while uart_tx is busy, then overflow
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count", {27'd0, count}, 32'd16);
    check("fill_overflow0", {31'd0, overflow}, 32'd0);
    write_byte(8'h10, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    force_busy = 1'b0;
    do_reset();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // 3. Three bytes through the uart_tx busy model
    base       = sends;
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) write_byte(8'(i), 1'b1);
    model_en   = 1'b1;
    force_busy = 1'b0;
    wait_sends(base + 3, 400, "t3_three_sends");
    repeat (100) step();
    check("t3_send_total", sends, base + 3);
    check("t3_queue_drained", exp_q.size(), 32'd0);
    model_en = 1'b0;
    wait_model_idle();

    // 4. Full FIFO, write and pop on the same edge
    do_reset();
    base       = sends;
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i), 1'b1);
    force_busy = 1'b0;
    write_byte(8'h30, 1'b1);
    check("wp_count", {27'd0, count}, 32'd16);
    check("wp_full", {31'd0, full}, 32'd1);
    check("wp_overflow", {31'd0, overflow}, 32'd0);
    wait_sends(base + 17, 600, "wp_drain");
    check("wp_empty", {31'd0, empty}, 32'd1);
    check("wp_queue_drained", exp_q.size(), 32'd0);

    // 5. Asynchronous reset in WAIT_LO with 5 entries queued
    do_reset();
    base       = sends;
    model_en   = 1'b1;
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) write_byte(8'h50 + 8'(i), 1'b1);
    force_busy = 1'b0;
    wait_sends(base + 1, 20, "t5_first_send");
    repeat (5) step();
    check("t5_count_before", {27'd0, count}, 32'd5);
    RST = 1'b1;
    #1;
    check("t5_rst_count", {27'd0, count}, 32'd0);
    check("t5_rst_empty", {31'd0, empty}, 32'd1);
    check("t5_rst_tx_send", {31'd0, tx_send}, 32'd0);
    exp_q.delete();
    step();
    RST  = 1'b0;
    base = sends;
    repeat (30) step();
    check("t5_busy_still", {31'd0, tx_busy}, 32'd1);
    check("t5_no_send", sends, base);
    model_en = 1'b0;
    wait_model_idle();
    check("t5_still_empty", {31'd0, empty}, 32'd1);

`ifdef UART_TX_FIFO_CRLF_EN
    // 6. LF expands to CR, LF
    do_reset();
    base = sends;
    exp_q.push_back(8'h0D);
    write_byte(8'h0A, 1'b0);
    exp_q.push_back(8'h0A);
    wait_sends(base + 2, 100, "crlf_two_sends");
    check("crlf_queue_drained", exp_q.size(), 32'd0);
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 15; i++) write_byte(8'h60 + 8'(i), 1'b1);
    write_byte(8'h0A, 1'b0);
    step();
    check("crlf_nospace_ovf", {31'd0, overflow}, 32'd1);
    check("crlf_nospace_count", {27'd0, count}, 32'd15);
    force_busy = 1'b0;
    do_reset();
`else
    // 6. Without expansion, LF is an ordinary byte
    do_reset();
    base       = sends;
    force_busy = 1'b1;
    write_byte(8'h0A, 1'b1);
    check("lf_plain_count", {27'd0, count}, 32'd1);
    force_busy = 1'b0;
    wait_sends(base + 1, 50, "lf_plain_send");
    check("lf_plain_drained", exp_q.size(), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
